// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared types and constants for the SRAM port controller
package sram_port_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int RSP_DEPTH      = 2;
    localparam int RSP_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      we;
        logic [RSP_DATA_WIDTH-1:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: 2-entry response buffer, head entry drives the outputs directly from a register
module sram_rsp_fifo #(
    parameter int W = $bits(sram_port_pkg::rsp_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] head, tail;

    // head is the oldest entry; tail only holds data while both slots are full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                head <= din;
            else if (pop && count == 2'd2)
                head <= tail;
            if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
                tail <= din;
        end
    end

    assign valid = count != 2'd0;
    assign dout  = head;

endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready front end for a 1-cycle-latency byte-write SRAM; SRAM_PORT_INIT_EN adds a zero-fill sweep after reset
module sram_port_ctrl
    import sram_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = RSP_DATA_WIDTH,
    parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_BYTE-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [NUM_BYTE-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  init_done_o
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep;
    logic                  init, issue, pop, inflight, inflight_we;
    logic [1:0]            count;
    logic [DATA_WIDTH:0]   fifo_dout;

`ifdef SRAM_PORT_INIT_EN
    state_t state_next;

    // state register and sweep address; reset always restarts the sweep at word 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_INIT;
            sweep <= '0;
        end else begin
            state <= state_next;
            sweep <= (state == ST_INIT) ? sweep + ADDR_WIDTH'(1) : '0;
        end
    end

    // leave INIT once the last word has been written
    always_comb state_next = (state == ST_INIT && &sweep) ? ST_RUN : state;
`else
    assign state = ST_RUN;
    assign sweep = '0;
`endif

    assign init        = state == ST_INIT;
    assign init_done_o = state == ST_RUN;
    assign pop         = rsp_valid_o & rsp_ready_i;
    // a slot freed by this cycle's pop can be reused by this cycle's request
    assign req_ready_o = !init && ({1'b0, count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    assign issue       = req_valid_i & req_ready_o;

    // RAM pins: sweep writes during INIT, request passthrough in RUN
    always_comb begin
        ram_en_o    = init | issue;
        ram_we_o    = init | req_we_i;
        ram_addr_o  = init ? sweep : req_addr_i;
        ram_wdata_o = init ? '0 : req_wdata_i;
        ram_be_o    = init ? '1 : (req_we_i ? req_be_i : '0);
    end

    // remember last cycle's issue so its response is captured when RAM data is valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight    <= 1'b0;
            inflight_we <= 1'b0;
        end else begin
            inflight    <= issue;
            inflight_we <= req_we_i;
        end
    end

    sram_rsp_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (inflight),
        .pop   (pop),
        .din   ({inflight_we, inflight_we ? {DATA_WIDTH{1'b0}} : ram_rdata_i}),
        .valid (rsp_valid_o),
        .dout  (fifo_dout),
        .count (count)
    );

    assign rsp_we_o    = fifo_dout[DATA_WIDTH];
    assign rsp_rdata_o = fifo_dout[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed bench for sram_port_ctrl against a 1-cycle byte-write RAM model
module tb_sram_port_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en, ram_we, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [NB-1:0] ram_be;

    logic [DW-1:0] mem [2**AW];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_we_o    (rsp_we),
        .rsp_rdata_o (rsp_rdata),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata),
        .init_done_o (init_done)
    );

    // RAM model with a bench-side preload port
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < NB; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else
                ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input string tag, input logic v, input logic we, input logic [31:0] d);
        chk(tag, {rsp_valid, v ? {rsp_we, rsp_rdata} : 33'b0}, {v, we, d});
    endtask

    task automatic step(input logic v, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic rr);
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        rsp_ready = rr;
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'hA5A5A5A5;
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        chk("rst_rsp", {rsp_valid, rsp_we, rsp_rdata}, 64'h0);
`ifdef SRAM_PORT_INIT_EN
        chk("rst_flags", {req_ready, ram_en, init_done}, {1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 2**AW; i++) begin
            chk("sweep", {ram_en, ram_we, ram_be, ram_wdata, ram_addr, req_ready, init_done},
                {1'b1, 1'b1, 4'hF, 32'h0, 8'(i), 1'b0, 1'b0});
            @(negedge clk);
            #1;
        end
        chk("init_done", {init_done, req_ready}, 2'b11);
        step(1, 0, 8'h10, 0, 4'hF, 1);
        chk("rd10_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h10});
        step(0, 0, 0, 0, 0, 1);
        rsp("rd10_lat1", 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        rsp("rd10_data", 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        rsp("rd10_done", 0, 0, 0);
`else
        chk("rst_flags", {req_ready, ram_en, init_done}, {1'b1, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run_first", {req_ready, init_done, ram_en}, {1'b1, 1'b1, 1'b0});
        step(0, 0, 0, 0, 0, 1);
        chk("idle_en", ram_en, 1'b0);
`endif
        // write, partial write, read back
        step(1, 1, 8'h05, 32'hDEADBEEF, 4'hF, 1);
        chk("w1_issue", {req_ready, ram_en, ram_we, ram_be, ram_addr}, {1'b1, 1'b1, 1'b1, 4'hF, 8'h05});
        rsp("w1_none", 0, 0, 0);
        step(1, 1, 8'h05, 32'h000000AA, 4'h1, 1);
        chk("w2_issue", {req_ready, ram_be, ram_wdata}, {1'b1, 4'h1, 32'h000000AA});
        rsp("w2_none", 0, 0, 0);
        step(1, 0, 8'h05, 32'h0, 4'hF, 1);
        chk("rd_be0", {req_ready, ram_en, ram_we, ram_be}, {1'b1, 1'b1, 1'b0, 4'h0});
        rsp("ack1", 1, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("idle_en2", ram_en, 1'b0);
        rsp("ack2", 1, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        rsp("rd5", 1, 0, 32'hDEADBEAA);
        step(0, 0, 0, 0, 0, 1);
        rsp("rd5_done", 0, 0, 0);
        // write with no byte enables is acknowledged but changes nothing
        step(1, 1, 8'h05, 32'hFFFFFFFF, 4'h0, 1);
        chk("be0_issue", {ram_en, ram_we}, 2'b11);
        step(1, 0, 8'h05, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        rsp("be0_ack", 1, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        rsp("be0_rd", 1, 0, 32'hDEADBEAA);
        // preload 1..4 then four back-to-back reads
        step(1, 1, 8'h01, 32'h11, 4'hF, 1);
        step(1, 1, 8'h02, 32'h22, 4'hF, 1);
        step(1, 1, 8'h03, 32'h33, 4'hF, 1);
        step(1, 1, 8'h04, 32'h44, 4'hF, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 8'h01, 0, 0, 1);
        chk("b2b_rdy0", req_ready, 1'b1);
        rsp("b2b_r0", 0, 0, 0);
        step(1, 0, 8'h02, 0, 0, 1);
        chk("b2b_rdy1", req_ready, 1'b1);
        rsp("b2b_r1", 0, 0, 0);
        step(1, 0, 8'h03, 0, 0, 1);
        chk("b2b_rdy2", req_ready, 1'b1);
        rsp("b2b_d1", 1, 0, 32'h11);
        step(1, 0, 8'h04, 0, 0, 1);
        chk("b2b_rdy3", req_ready, 1'b1);
        rsp("b2b_d2", 1, 0, 32'h22);
        step(0, 0, 0, 0, 0, 1);
        rsp("b2b_d3", 1, 0, 32'h33);
        step(0, 0, 0, 0, 0, 1);
        rsp("b2b_d4", 1, 0, 32'h44);
        step(0, 0, 0, 0, 0, 1);
        rsp("b2b_end", 0, 0, 0);
        // backpressure: two outstanding, then stall until a pop
        step(1, 0, 8'h01, 0, 0, 0);
        chk("bp_acc1", req_ready, 1'b1);
        step(1, 0, 8'h02, 0, 0, 0);
        chk("bp_acc2", req_ready, 1'b1);
        step(1, 0, 8'h03, 0, 0, 0);
        chk("bp_stall1", {req_ready, ram_en}, 2'b00);
        rsp("bp_hold1", 1, 0, 32'h11);
        step(1, 0, 8'h03, 0, 0, 0);
        chk("bp_stall2", {req_ready, ram_en}, 2'b00);
        rsp("bp_hold2", 1, 0, 32'h11);
        step(1, 0, 8'h03, 0, 0, 1);
        chk("bp_pop_acc", {req_ready, ram_en, ram_addr}, {1'b1, 1'b1, 8'h03});
        rsp("bp_d1", 1, 0, 32'h11);
        step(0, 0, 0, 0, 0, 1);
        rsp("bp_d2", 1, 0, 32'h22);
        step(0, 0, 0, 0, 0, 1);
        rsp("bp_d3", 1, 0, 32'h33);
        step(0, 0, 0, 0, 0, 1);
        rsp("bp_end", 0, 0, 0);
        // reset with two responses pending
        step(1, 0, 8'h01, 0, 0, 0);
        step(1, 0, 8'h02, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        rsp("pend", 1, 0, 32'h11);
        #1 rst_n = 1'b0;
        #1;
        chk("async_clr", rsp_valid, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
`ifdef SRAM_PORT_INIT_EN
        chk("resweep", {ram_en, ram_we, ram_addr, req_ready, init_done}, {1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
        rsp("resweep_rsp", 0, 0, 0);
        repeat (2**AW) step(0, 0, 0, 0, 0, 1);
        chk("redone", {init_done, req_ready}, 2'b11);
`else
        chk("rerun", {req_ready, init_done, ram_en}, {1'b1, 1'b1, 1'b0});
`endif
        rsp("drop0", 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        rsp("drop1", 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        rsp("drop2", 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
